// File: rtl/icache_sa_if.sv
// Fetcher / Memory Controller bus of the set-associative instruction cache.
// The cache side uses the slave modport; the environment driving it uses master.
interface icache_sa_if #(
   parameter int XLEN = 32
);
   logic            fet_icache_enable;
   logic [XLEN-1:0] fet_pc;
   logic            icache_ready;
   logic [XLEN-1:0] icache_inst;
   logic            mem_busy;
   logic            mem_inst_ready;
   logic [XLEN-1:0] mem_inst;
   logic [XLEN-1:0] mem_inst_addr;
   logic            icache_mem_enable;
   logic [XLEN-1:0] icache_inst_addr;

   modport master (
      output fet_icache_enable, fet_pc, mem_busy, mem_inst_ready, mem_inst, mem_inst_addr,
      input  icache_ready, icache_inst, icache_mem_enable, icache_inst_addr
   );

   modport slave (
      input  fet_icache_enable, fet_pc, mem_busy, mem_inst_ready, mem_inst, mem_inst_addr,
      output icache_ready, icache_inst, icache_mem_enable, icache_inst_addr
   );
endinterface

// File: rtl/icache_sa.sv
// Set-associative, RV32C-aware instruction cache with a word-burst refill FSM,
// per-set round-robin replacement and hit/miss counters.
module icache_sa #(
   parameter int XLEN       = 32,
   parameter int WAYS       = 2,
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        flush,
   input  logic        stall,
   icache_sa_if.slave  bus,
   output logic [31:0] icache_hit_cnt,
   output logic [31:0] icache_miss_cnt
);

   localparam int OFF_W  = $clog2(LINE_WORDS * 4);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = XLEN - IDX_W - OFF_W;
   localparam int LINE_W = XLEN - OFF_W;
   localparam int WORD_W = $clog2(LINE_WORDS);
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

   logic [SETS-1:0]  valid    [WAYS];
   logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
   logic [XLEN-1:0]  data_mem [WAYS][SETS][LINE_WORDS];
   logic [WAY_W-1:0] rr       [SETS];

   state_t            state;
   logic [LINE_W-1:0] line_q;
   logic [WAY_W-1:0]  way_q;
   logic [WORD_W-1:0] word_q;
   logic              mem_en_q;
   logic [XLEN-1:0]   req_addr_q;

   // Line A holds the halfword at pc, line B the halfword at pc+2 (same line unless straddling).
   logic [XLEN-1:0]   pc_a, pc_b;
   logic [IDX_W-1:0]  idx_a, idx_b;
   logic [TAG_W-1:0]  tag_a, tag_b;
   logic [WORD_W-1:0] woff_a, woff_b;
   logic [WAYS-1:0]   match_a, match_b;
   logic              hit_a, hit_b;
   logic [XLEN-1:0]   word_a, word_b;
   logic [15:0]       half_a, half_b;
   logic              c_ext, lookup_ok;
   logic              unused_pc_bits;

   assign pc_a   = bus.fet_pc;
   assign pc_b   = bus.fet_pc + XLEN'(2);
   assign idx_a  = pc_a[OFF_W +: IDX_W];
   assign idx_b  = pc_b[OFF_W +: IDX_W];
   assign tag_a  = pc_a[XLEN-1 -: TAG_W];
   assign tag_b  = pc_b[XLEN-1 -: TAG_W];
   assign woff_a = pc_a[2 +: WORD_W];
   assign woff_b = pc_b[2 +: WORD_W];
   assign unused_pc_bits = pc_a[0] ^ pc_b[0];

   // Tag compare across all ways for both halfword addresses.
   always_comb begin
      // NOTE: every signal gets a default first so no latch is inferred.
      match_a = '0;
      match_b = '0;
      hit_a   = 1'b0;
      hit_b   = 1'b0;
      word_a  = '0;
      word_b  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid[w][idx_a] && tag_mem[w][idx_a] == tag_a) begin
            match_a[w] = 1'b1;
            hit_a      = 1'b1;
            word_a     = data_mem[w][idx_a][woff_a];
         end
         if (valid[w][idx_b] && tag_mem[w][idx_b] == tag_b) begin
            match_b[w] = 1'b1;
            hit_b      = 1'b1;
            word_b     = data_mem[w][idx_b][woff_b];
         end
      end
   end

   assign half_a    = pc_a[1] ? word_a[31:16] : word_a[15:0];
   assign half_b    = pc_b[1] ? word_b[31:16] : word_b[15:0];
   assign c_ext     = (half_a[1:0] != 2'b11);
   assign lookup_ok = hit_a && (c_ext || hit_b);

   assign bus.icache_ready      = lookup_ok;
   assign bus.icache_inst       = !lookup_ok ? '0 :
                                  c_ext      ? XLEN'({16'b0, half_a}) : XLEN'({half_b, half_a});
   assign bus.icache_mem_enable = mem_en_q;
   assign bus.icache_inst_addr  = req_addr_q;

   // Refill target: line A if it misses, otherwise the straddled line B.
   logic [LINE_W-1:0] miss_line;
   logic [IDX_W-1:0]  miss_idx;
   logic              miss_start, resp_match, last_word, refill_we;

   assign miss_line  = hit_a ? pc_b[XLEN-1:OFF_W] : pc_a[XLEN-1:OFF_W];
   assign miss_idx   = miss_line[IDX_W-1:0];
   assign miss_start = rdy && (state == S_IDLE) && bus.fet_icache_enable && !lookup_ok
                       && !stall && !flush;
   assign resp_match = bus.mem_inst_ready && (bus.mem_inst_addr == req_addr_q);
   assign last_word  = (word_q == WORD_W'(LINE_WORDS - 1));
   assign refill_we  = rdy && (state == S_WAIT) && resp_match;

   // Refill FSM, valid bits, replacement pointers, request pulse and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_IDLE;
         line_q          <= '0;
         way_q           <= '0;
         word_q          <= '0;
         mem_en_q        <= 1'b0;
         req_addr_q      <= '0;
         icache_hit_cnt  <= '0;
         icache_miss_cnt <= '0;
         for (int w = 0; w < WAYS; w++) valid[w] <= '0;
         for (int s = 0; s < SETS; s++) rr[s] <= '0;
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments only.
         mem_en_q <= 1'b0;
         if (rdy) begin
            if (lookup_ok && bus.fet_icache_enable && !stall)
               icache_hit_cnt <= icache_hit_cnt + 32'd1;
            case (state)
               S_IDLE: begin
                  if (miss_start) begin
                     line_q                       <= miss_line;
                     way_q                        <= rr[miss_idx];
                     valid[rr[miss_idx]][miss_idx] <= 1'b0;
                     rr[miss_idx]                 <= (rr[miss_idx] == WAY_W'(WAYS - 1)) ? '0
                                                     : rr[miss_idx] + WAY_W'(1);
                     icache_miss_cnt              <= icache_miss_cnt + 32'd1;
                     word_q                       <= '0;
                     state                        <= S_REQ;
                  end
               end
               S_REQ: begin
                  if (flush) begin
                     state <= S_IDLE;
                  end else if (!bus.mem_busy && !stall) begin
                     mem_en_q   <= 1'b1;
                     req_addr_q <= {line_q, word_q, 2'b00};
                     state      <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (resp_match) begin
                     if (flush) begin
                        state <= S_IDLE;
                     end else if (last_word) begin
                        valid[way_q][line_q[IDX_W-1:0]] <= 1'b1;
                        state                           <= S_IDLE;
                     end else begin
                        word_q <= word_q + WORD_W'(1);
                        state  <= S_REQ;
                     end
                  end else if (flush) begin
                     state <= S_DRAIN;
                  end
               end
               S_DRAIN: begin
                  if (resp_match) state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // Tag and data array writes from refill responses.
   always_ff @(posedge clk) begin
      // NOTE: tag/data arrays are not reset; the valid bits alone decide what can hit.
      if (refill_we) begin
         data_mem[way_q][line_q[IDX_W-1:0]][word_q] <= bus.mem_inst;
         if (last_word) tag_mem[way_q][line_q[IDX_W-1:0]] <= line_q[LINE_W-1 -: TAG_W];
      end
   end

   // A line may live in at most one way of its set.
   a_one_way_hit: assert property (@(posedge clk) disable iff (rst)
                                   $onehot0(match_a) && $onehot0(match_b));

endmodule
